// File: rtl/hamming_serial_decoder.sv
// Bit-serial Hamming decoder: collects 2**R-1 codeword bits over valid/ready, then holds the corrected word.
// Optional HAMMING_SECDED_EN adds an overall-parity bit (index N) and a double-error flag.
module hamming_serial_decoder #(
  parameter int unsigned R = 3,
  localparam int unsigned N = (2 ** R) - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_word,
  output logic [R-1:0] out_syndrome,
`ifdef HAMMING_SECDED_EN
  output logic         out_dbl_err,
`endif
  output logic         out_err
);

`ifdef HAMMING_SECDED_EN
  localparam int unsigned LAST = N;
`else
  localparam int unsigned LAST = N - 1;
`endif

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic         in_ready_d;
  logic         out_valid_d;
  logic         accept;
  logic         last;
  logic [R-1:0] cnt_q, cnt_d;
  logic [R-1:0] syn_q, syn_d, syn_term;
  logic [N-1:0] word_q, word_rx;
  logic [N-1:0] fix_mask, word_fixed;
  logic [N-1:0] out_word_d;
  logic         out_err_d;
`ifdef HAMMING_SECDED_EN
  logic         par_q, par_d;
  logic         p_ok;
  logic         out_dbl_d;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= COLLECT;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state and registered handshake targets
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (in_valid && (cnt_q == R'(LAST))) state_d = HOLD;
      HOLD:    if (out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
    in_ready_d  = (state_d == COLLECT);
    out_valid_d = (state_d == HOLD);
  end

  assign accept = (state_q == COLLECT) && in_valid;
  assign last   = accept && (cnt_q == R'(LAST));

  // Syndrome accumulation, word assembly and correction including the bit on the input
  always_comb begin
    syn_term = '0;
    word_rx  = word_q;
    if (cnt_q < R'(N)) begin
      word_rx[cnt_q] = in_bit;
      if (in_bit) syn_term = cnt_q + R'(1);
    end
    syn_d      = syn_q ^ syn_term;
    cnt_d      = last ? '0 : cnt_q + R'(1);
    fix_mask   = (syn_d != '0) ? (N'(1) << (syn_d - R'(1))) : '0;
    word_fixed = word_rx ^ fix_mask;
`ifdef HAMMING_SECDED_EN
    par_d      = par_q ^ in_bit;
    p_ok       = ~par_d;
    out_word_d = word_rx;
    out_err_d  = 1'b0;
    out_dbl_d  = 1'b0;
    if ((syn_d != '0) && !p_ok) begin
      out_word_d = word_fixed;
      out_err_d  = 1'b1;
    end else if (syn_d != '0) begin
      out_dbl_d  = 1'b1;
    end else if (!p_ok) begin
      out_err_d  = 1'b1;
    end
`else
    out_word_d = word_fixed;
    out_err_d  = (syn_d != '0);
`endif
  end

  // Datapath registers; accumulators clear as the final bit is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      syn_q        <= '0;
      word_q       <= '0;
      out_word     <= '0;
      out_syndrome <= '0;
      out_err      <= 1'b0;
`ifdef HAMMING_SECDED_EN
      par_q        <= 1'b0;
      out_dbl_err  <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q  <= cnt_d;
      syn_q  <= last ? '0 : syn_d;
      word_q <= last ? '0 : word_rx;
`ifdef HAMMING_SECDED_EN
      par_q  <= last ? 1'b0 : par_d;
`endif
      if (last) begin
        out_word     <= out_word_d;
        out_syndrome <= syn_d;
        out_err      <= out_err_d;
`ifdef HAMMING_SECDED_EN
        out_dbl_err  <= out_dbl_d;
`endif
      end
    end
  end

endmodule
